// File: rtl/acc_frame_src_pkg.sv
// Shared definitions for the accumulator frame source: default widths and
// the 2-bit FSM state encodings also used by the sig_acc benches.
package acc_frame_src_pkg;

    localparam int DEF_DIN_WIDTH  = 16;
    localparam int DEF_VEC_LEN    = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

endpackage

// File: rtl/acc_frame_src_if.sv
// Bus bundle for acc_frame_src: buffer write port, frame control, and the
// din/en/last stream towards the accumulator plus status back upstream.
interface acc_frame_src_if
    import acc_frame_src_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic signed [DIN_WIDTH-1:0] wr_data;
    logic [LEN_WIDTH-1:0]        frame_len;
    logic                        start;
    logic                        pause;
    logic                        acc_valid;
    logic signed [DIN_WIDTH-1:0] dout;
    logic                        en;
    logic                        last;
    logic                        busy;
    logic                        done;

    // The frame source itself.
    modport master (
        input  wr_en, wr_addr, wr_data, frame_len, start, pause, acc_valid,
        output dout, en, last, busy, done
    );

    // Loader / accumulator side.
    modport slave (
        output wr_en, wr_addr, wr_data, frame_len, start, pause, acc_valid,
        input  dout, en, last, busy, done
    );
endinterface

// File: rtl/acc_frame_buf.sv
// VEC_LEN x DIN_WIDTH register-file sample buffer: one write port, one
// registered read port. Contents survive reset; only the read register clears.
module acc_frame_buf
    import acc_frame_src_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int VEC_LEN    = DEF_VEC_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic signed [DIN_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic signed [DIN_WIDTH-1:0] rd_data
);
    logic signed [DIN_WIDTH-1:0] mem_q [VEC_LEN];
    logic signed [DIN_WIDTH-1:0] rd_data_q;

    // Storage write; addresses past the buffer depth are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < VEC_LEN)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value whenever no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/acc_frame_src.sv
// Framed sample source for sig_acc-style accumulators. Streams len samples
// from the internal buffer with en/last, then one idle GAP cycle.
// Optional macro ACC_FRAME_SRC_WAIT_RESULT_EN: after GAP, hold busy until the
// accumulator reports acc_valid, then pulse done.
module acc_frame_src
    import acc_frame_src_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int VEC_LEN    = DEF_VEC_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input logic            clk,
    input logic            rst,
    acc_frame_src_if.master bus
);
    state_e                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic                        en_q, en_d;
    logic                        last_q, last_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [LEN_WIDTH-1:0]        len_clamped;
    logic                        rd_en;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic signed [DIN_WIDTH-1:0] rd_data;

`ifndef ACC_FRAME_SRC_WAIT_RESULT_EN
    // Accumulator result handshake is not used in this build.
    logic unused_acc_valid;
    assign unused_acc_valid = bus.acc_valid;
`endif

    assign len_clamped = (32'(bus.frame_len) > VEC_LEN) ? LEN_WIDTH'(VEC_LEN) : bus.frame_len;

    acc_frame_buf #(
        .DIN_WIDTH  (DIN_WIDTH),
        .VEC_LEN    (VEC_LEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en && !busy_q),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state logic: each beat is fetched one edge ahead so the buffer's
    // read register doubles as the dout register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        en_d    = 1'b0;
        last_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.frame_len != '0)) begin
                    len_d   = len_clamped;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    en_d    = 1'b1;
                    last_d  = (len_clamped == LEN_WIDTH'(1));
                    addr_d  = ADDR_WIDTH'(1);
                    busy_d  = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // The last beat is already on the bus: move to the idle gap.
                // Otherwise issue a beat unless downstream holds us.
                if (last_q) begin
                    state_d = ST_GAP;
                end else if (!bus.pause) begin
                    rd_en  = 1'b1;
                    en_d   = 1'b1;
                    last_d = (LEN_WIDTH'(addr_q) == (len_q - LEN_WIDTH'(1)));
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_GAP: begin
`ifdef ACC_FRAME_SRC_WAIT_RESULT_EN
                // A result arriving during the gap skips WAIT entirely.
                if (bus.acc_valid) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`endif
            end
            ST_WAIT: begin
`ifdef ACC_FRAME_SRC_WAIT_RESULT_EN
                if (bus.acc_valid) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            en_q    <= en_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout = rd_data;
    assign bus.en   = en_q;
    assign bus.last = last_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_acc_frame_src.sv
// Directed bench for acc_frame_src with a beat scoreboard: expected samples
// are queued when a frame is started and popped as en beats appear.
// Works in both builds (ACC_FRAME_SRC_WAIT_RESULT_EN defined or not).
module tb_acc_frame_src;
    localparam int VEC = 8;

    typedef struct packed {
        logic signed [15:0] dout;
        logic               last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   fail_cnt  = 0;
    beat_t exp_q[$];
    logic signed [15:0] model_mem [VEC];

    acc_frame_src_if bus ();

    acc_frame_src dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every en beat must match the next queued sample.
    always @(negedge clk) begin
        if (bus.last) begin
            tests_run++;
            assert (bus.en === 1'b1) else begin
                fail_cnt++;
                $error("FAIL last_without_en: observed en=%0b expected 1", bus.en);
            end
        end
        if (bus.en === 1'b1) begin
            tests_run++;
            assert (exp_q.size() > 0) else begin
                fail_cnt++;
                $error("FAIL sb_underflow: observed beat %0h expected no beat", bus.dout);
            end
            if (exp_q.size() > 0) begin
                beat_t e;
                e = exp_q.pop_front();
                tests_run++;
                assert ({bus.dout, bus.last} === {e.dout, e.last}) else begin
                    fail_cnt++;
                    $error("FAIL beat: observed dout=%0h last=%0b expected dout=%0h last=%0b",
                           bus.dout, bus.last, e.dout, e.last);
                end
            end
        end
    end

    task automatic write_buf(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = 16'(d);
        model_mem[a] = 16'(d);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic start_frame(input int len);
        int n;
        beat_t b;
        n = (len > VEC) ? VEC : len;
        for (int i = 0; i < n; i++) begin
            b.dout = model_mem[i];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        bus.frame_len = 4'(len);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Observe one frame cycle by cycle (cycle 0 = first beat slot), driving
    // pause/acc_valid/mid-frame pokes at the negedge for the following edge.
    task automatic watch(input int acc_delay, input logic [31:0] pmask, input bit poke,
                         output int beats, output int busy_cyc, output int last_cnt,
                         output int done_cnt, output int last_cyc, output int done_cyc);
        int cyc;
        logic signed [15:0] prev;
        beats = 0; busy_cyc = 0; last_cnt = 0; done_cnt = 0;
        last_cyc = -1; done_cyc = -1; cyc = 0;
        prev = bus.dout;
        while (cyc < 64 && (done_cyc < 0 || cyc <= done_cyc + 1)) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.en) beats++;
            else if (bus.busy) check("dout_hold", 32'(bus.dout), 32'(prev));
            prev = bus.dout;
            if (bus.last) begin
                last_cnt++;
                last_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                end
            end
            bus.pause     = (cyc < 32) ? pmask[cyc] : 1'b0;
            bus.acc_valid = (acc_delay >= 0 && last_cyc >= 0 && cyc == last_cyc + 1 + acc_delay);
            if (poke && cyc == 2) begin
                bus.start = 1'b1; bus.frame_len = 4'd3;
                bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'sh1234;
            end else if (poke && cyc == 3) begin
                bus.start = 1'b0; bus.wr_en = 1'b0;
            end
            cyc++;
        end
        bus.pause = 1'b0;
        bus.acc_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int len, input int acc_delay,
                             input logic [31:0] pmask, input int paused, input bit poke);
        int n, beats, busy_cyc, last_cnt, done_cnt, last_cyc, done_cyc, extra;
        n = (len > VEC) ? VEC : len;
`ifdef ACC_FRAME_SRC_WAIT_RESULT_EN
        extra = acc_delay;
`else
        extra = 0;
`endif
        start_frame(len);
        watch(acc_delay, pmask, poke, beats, busy_cyc, last_cnt, done_cnt, last_cyc, done_cyc);
        check({tag, ":beats"}, beats, n);
        check({tag, ":last_cnt"}, last_cnt, 1);
        check({tag, ":last_cyc"}, last_cyc, n + paused - 1);
        check({tag, ":done_cnt"}, done_cnt, 1);
        check({tag, ":done_cyc"}, done_cyc, n + paused + 1 + extra);
        check({tag, ":busy_cyc"}, busy_cyc, n + paused + 1 + extra);
        check({tag, ":sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals [VEC] = '{3, -2, 7, -8, 1, 0, 5, -1};
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.frame_len = '0; bus.start = 1'b0; bus.pause = 1'b0; bus.acc_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:dout", 32'(bus.dout), 32'd0);
        check("rst:en",   32'(bus.en),   32'd0);
        check("rst:last", 32'(bus.last), 32'd0);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < VEC; i++) write_buf(i, vals[i]);
        run_frame("full8", 8, 0, 32'h0, 0, 1'b0);

        write_buf(0, -32768);
        run_frame("len1", 1, 0, 32'h0, 0, 1'b0);

        // Beats 2 and 4 each held off for two cycles.
        run_frame("pause", 4, 0, 32'h33, 4, 1'b0);

        // Mid-frame start and write must both be ignored.
        run_frame("busy_poke", 8, 0, 32'h0, 0, 1'b1);
        run_frame("after_poke", 3, 0, 32'h0, 0, 1'b0);

        run_frame("clamp", 15, 0, 32'h0, 0, 1'b0);

        // frame_len of zero starts nothing.
        start_frame(0);
        repeat (3) begin
            @(negedge clk);
            check("len0:busy", 32'(bus.busy), 32'd0);
            check("len0:en",   32'(bus.en),   32'd0);
        end

        // Reset during the third beat of eight aborts the frame silently.
        start_frame(8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst:dout", 32'(bus.dout), 32'd0);
        check("midrst:en",   32'(bus.en),   32'd0);
        check("midrst:last", 32'(bus.last), 32'd0);
        check("midrst:busy", 32'(bus.busy), 32'd0);
        check("midrst:done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("midrst:idle_busy", 32'(bus.busy), 32'd0);
        end
        run_frame("post_rst", 8, 0, 32'h0, 0, 1'b0);

        // Result handshake arriving five cycles after the gap.
        run_frame("acc_wait", 2, 5, 32'h0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
